// File: rtl/tx_pkg.sv
// Shared transmit-path definitions: stream widths, arbiter state encoding
// and source identifiers used by the arbiter and the send buffers.
`timescale 1ns/1ps
package tx_pkg;

    localparam int DATA_W = 32;
    localparam int KEEP_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        GRANT_ARP = 2'd1,
        GRANT_IP  = 2'd2
    } arb_state_t;

    localparam logic SRC_IP  = 1'b0;
    localparam logic SRC_ARP = 1'b1;

endpackage

// File: rtl/tx_arb_mux.sv
// Combinational payload and handshake mux for the transmit arbiter.
// Only the granted source sees m_tready; with no grant the output is all zero.
`timescale 1ns/1ps
module tx_arb_mux
#(
    parameter int DATA_W = tx_pkg::DATA_W,
    parameter int KEEP_W = tx_pkg::KEEP_W
)
(
    input  logic              grant_arp,
    input  logic              grant_ip,
    input  logic [DATA_W-1:0] ip_tdata,
    input  logic [KEEP_W-1:0] ip_tkeep,
    input  logic              ip_tvalid,
    input  logic              ip_tlast,
    output logic              ip_tready,
    input  logic [DATA_W-1:0] arp_tdata,
    input  logic [KEEP_W-1:0] arp_tkeep,
    input  logic              arp_tvalid,
    input  logic              arp_tlast,
    output logic              arp_tready,
    output logic [DATA_W-1:0] m_tdata,
    output logic [KEEP_W-1:0] m_tkeep,
    output logic              m_tvalid,
    output logic              m_tlast,
    input  logic              m_tready
);

    // Route the granted source straight through; everything else is held at zero.
    always_comb begin
        m_tdata    = '0;
        m_tkeep    = '0;
        m_tvalid   = 1'b0;
        m_tlast    = 1'b0;
        ip_tready  = 1'b0;
        arp_tready = 1'b0;
        if (grant_arp) begin
            m_tdata    = arp_tdata;
            m_tkeep    = arp_tkeep;
            m_tvalid   = arp_tvalid;
            m_tlast    = arp_tlast;
            arp_tready = m_tready;
        end else if (grant_ip) begin
            m_tdata   = ip_tdata;
            m_tkeep   = ip_tkeep;
            m_tvalid  = ip_tvalid;
            m_tlast   = ip_tlast;
            ip_tready = m_tready;
        end
    end

endmodule

// File: rtl/tx_frame_arbiter.sv
// Frame-granular arbiter merging the ARP and IP transmit streams onto one
// AXI-stream. ARP wins ties unless IP has been passed over STARVE_LIMIT times.
// Optional build macro TX_ARB_STATS_EN adds per-source frame counters.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | no owner; pick next source from the tvalid inputs this cycle
// GRANT_ARP | ARP frame in flight, held until its tlast beat is accepted
// GRANT_IP  | IP frame in flight, held until its tlast beat is accepted
`timescale 1ns/1ps
module tx_frame_arbiter
#(
    parameter int DATA_W       = tx_pkg::DATA_W,
    parameter int KEEP_W       = tx_pkg::KEEP_W,
    parameter int STARVE_LIMIT = 4
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] ip_tdata,
    input  logic [KEEP_W-1:0] ip_tkeep,
    input  logic              ip_tvalid,
    input  logic              ip_tlast,
    output logic              ip_tready,
    input  logic [DATA_W-1:0] arp_tdata,
    input  logic [KEEP_W-1:0] arp_tkeep,
    input  logic              arp_tvalid,
    input  logic              arp_tlast,
    output logic              arp_tready,
    output logic [DATA_W-1:0] m_tdata,
    output logic [KEEP_W-1:0] m_tkeep,
    output logic              m_tvalid,
    output logic              m_tlast,
    input  logic              m_tready,
    output logic              grant_arp,
    output logic              grant_ip,
    output logic              busy,
    output logic [15:0]       ip_frames,
    output logic [15:0]       arp_frames
);

    import tx_pkg::*;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    arb_state_t state;
    logic [3:0] starve_cnt;
    logic       ip_done;
    logic       arp_done;
    logic       ip_starved;

    // tready is only ever high for the granted source, so these mark accepted tlast beats
    assign ip_done    = ip_tvalid  & ip_tready  & ip_tlast;
    assign arp_done   = arp_tvalid & arp_tready & arp_tlast;
    assign ip_starved = ip_tvalid & (starve_cnt == LIMIT);

    // Arbitration FSM with registered grants, busy flag and starvation counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            grant_arp  <= 1'b0;
            grant_ip   <= 1'b0;
            busy       <= 1'b0;
            starve_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (arp_tvalid && !ip_starved) begin
                        state     <= GRANT_ARP;
                        grant_arp <= 1'b1;
                        busy      <= 1'b1;
                        // ip_starved is false here, so the count is below LIMIT
                        if (ip_tvalid)
                            starve_cnt <= starve_cnt + 4'd1;
                    end else if (ip_tvalid) begin
                        state      <= GRANT_IP;
                        grant_ip   <= 1'b1;
                        busy       <= 1'b1;
                        starve_cnt <= '0;
                    end
                end
                GRANT_ARP: begin
                    if (arp_done) begin
                        state     <= IDLE;
                        grant_arp <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                GRANT_IP: begin
                    if (ip_done) begin
                        state    <= IDLE;
                        grant_ip <= 1'b0;
                        busy     <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    grant_arp <= 1'b0;
                    grant_ip  <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    tx_arb_mux #(
        .DATA_W (DATA_W),
        .KEEP_W (KEEP_W)
    ) u_mux (
        .grant_arp  (grant_arp),
        .grant_ip   (grant_ip),
        .ip_tdata   (ip_tdata),
        .ip_tkeep   (ip_tkeep),
        .ip_tvalid  (ip_tvalid),
        .ip_tlast   (ip_tlast),
        .ip_tready  (ip_tready),
        .arp_tdata  (arp_tdata),
        .arp_tkeep  (arp_tkeep),
        .arp_tvalid (arp_tvalid),
        .arp_tlast  (arp_tlast),
        .arp_tready (arp_tready),
        .m_tdata    (m_tdata),
        .m_tkeep    (m_tkeep),
        .m_tvalid   (m_tvalid),
        .m_tlast    (m_tlast),
        .m_tready   (m_tready)
    );

`ifdef TX_ARB_STATS_EN
    logic [15:0] ip_cnt;
    logic [15:0] arp_cnt;

    // Count completed frames per source, wrapping at 2^16
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ip_cnt  <= '0;
            arp_cnt <= '0;
        end else begin
            if (ip_done)
                ip_cnt <= ip_cnt + 16'd1;
            if (arp_done)
                arp_cnt <= arp_cnt + 16'd1;
        end
    end

    assign ip_frames  = ip_cnt;
    assign arp_frames = arp_cnt;
`else
    assign ip_frames  = '0;
    assign arp_frames = '0;
`endif

endmodule

// File: tb/tb_tx_frame_arbiter.sv
// Self-checking bench for tx_frame_arbiter: expected output beats are queued
// as stimulus is planned and matched against every accepted output beat.
`timescale 1ns/1ps
module tb_tx_frame_arbiter;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } beat_t;

    logic        clk;
    logic        reset;
    logic [31:0] ip_tdata;
    logic [3:0]  ip_tkeep;
    logic        ip_tvalid;
    logic        ip_tlast;
    logic        ip_tready;
    logic [31:0] arp_tdata;
    logic [3:0]  arp_tkeep;
    logic        arp_tvalid;
    logic        arp_tlast;
    logic        arp_tready;
    logic [31:0] m_tdata;
    logic [3:0]  m_tkeep;
    logic        m_tvalid;
    logic        m_tlast;
    logic        m_tready;
    logic        grant_arp;
    logic        grant_ip;
    logic        busy;
    logic [15:0] ip_frames;
    logic [15:0] arp_frames;

    int    checks = 0;
    int    errors = 0;
    int    cyc    = 0;
    beat_t exp_q[$];

    tx_frame_arbiter #(.DATA_W(32), .KEEP_W(4), .STARVE_LIMIT(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .ip_tdata   (ip_tdata),
        .ip_tkeep   (ip_tkeep),
        .ip_tvalid  (ip_tvalid),
        .ip_tlast   (ip_tlast),
        .ip_tready  (ip_tready),
        .arp_tdata  (arp_tdata),
        .arp_tkeep  (arp_tkeep),
        .arp_tvalid (arp_tvalid),
        .arp_tlast  (arp_tlast),
        .arp_tready (arp_tready),
        .m_tdata    (m_tdata),
        .m_tkeep    (m_tkeep),
        .m_tvalid   (m_tvalid),
        .m_tlast    (m_tlast),
        .m_tready   (m_tready),
        .grant_arp  (grant_arp),
        .grant_ip   (grant_ip),
        .busy       (busy),
        .ip_frames  (ip_frames),
        .arp_frames (arp_frames)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard: a beat is accepted at the next rising edge when valid and ready at the falling edge
    always @(negedge clk) begin
        beat_t e;
        if (!reset && m_tvalid && m_tready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_extra: got data=%h keep=%h last=%b, expected no beat",
                         m_tdata, m_tkeep, m_tlast);
            end else begin
                e = exp_q.pop_front();
                if ({m_tdata, m_tkeep, m_tlast} !== {e.data, e.keep, e.last}) begin
                    errors++;
                    $display("FAIL scoreboard_beat: got data=%h keep=%h last=%b, expected data=%h keep=%h last=%b",
                             m_tdata, m_tkeep, m_tlast, e.data, e.keep, e.last);
                end
            end
        end
    end

    function automatic beat_t mk_beat(input bit is_arp, input int tag, input int b,
                                      input int n, input logic [3:0] lk);
        beat_t bt;
        bt.data = {(is_arp ? 8'hAA : 8'h55), tag[7:0], b[15:0]};
        bt.keep = (b == n - 1) ? lk : 4'hF;
        bt.last = (b == n - 1);
        return bt;
    endfunction

    task automatic push_frame(input bit is_arp, input int n, input int tag, input logic [3:0] lk);
        for (int b = 0; b < n; b++) exp_q.push_back(mk_beat(is_arp, tag, b, n, lk));
    endtask

    task automatic drive_src(input bit is_arp, input beat_t bt, input logic v);
        if (is_arp) begin
            arp_tdata = bt.data; arp_tkeep = bt.keep; arp_tlast = bt.last; arp_tvalid = v;
        end else begin
            ip_tdata = bt.data; ip_tkeep = bt.keep; ip_tlast = bt.last; ip_tvalid = v;
        end
    endtask

    // Present a frame beat by beat; called just after a rising edge, returns just after one
    task automatic send_frame(input bit is_arp, input int n, input int tag, input logic [3:0] lk);
        for (int b = 0; b < n; b++) begin
            int guard;
            drive_src(is_arp, mk_beat(is_arp, tag, b, n, lk), 1'b1);
            guard = 0;
            @(negedge clk);
            while (!(is_arp ? arp_tready : ip_tready) && guard <= 1000) begin
                guard++;
                @(negedge clk);
            end
            if (guard > 1000) begin
                checks++;
                errors++;
                $display("FAIL handshake_timeout: src_arp=%0b tag=%0d beat=%0d not accepted, required within 1000 cycles",
                         is_arp, tag, b);
                drive_src(is_arp, '0, 1'b0);
                return;
            end
            @(posedge clk);
            #1;
        end
        drive_src(is_arp, '0, 1'b0);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        ip_tvalid = 1'b1;
        arp_tvalid = 1'b1;
        m_tready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({m_tdata, m_tkeep, m_tvalid, m_tlast, ip_tready, arp_tready, grant_arp, grant_ip, busy,
             ip_frames, arp_frames} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got tvalid=%b tready=%b/%b grant=%b/%b busy=%b data=%h, required all 0",
                     m_tvalid, ip_tready, arp_tready, grant_arp, grant_ip, busy, m_tdata);
        end
        ip_tvalid = 1'b0;
        arp_tvalid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, grant_arp, grant_ip, m_tvalid} !== 4'b0) begin
            errors++;
            $display("FAIL reset_idle: got busy=%b grant=%b/%b tvalid=%b, required 0", busy, grant_arp, grant_ip, m_tvalid);
        end
    endtask

    task automatic test_single_ip;
        int start;
        m_tready = 1'b1;
        push_frame(0, 5, 1, 4'b0011);
        start = cyc;
        send_frame(0, 5, 1, 4'b0011);
        checks++;
        if (cyc - start != 6) begin
            errors++;
            $display("FAIL single_ip_latency: got %0d cycles, required 6", cyc - start);
        end
        @(negedge clk);
        checks++;
        if ({busy, grant_ip} !== 2'b00) begin
            errors++;
            $display("FAIL single_ip_busy_drop: got busy=%b grant_ip=%b, required 0", busy, grant_ip);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL single_ip_drain: got %0d beats outstanding, required 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_simultaneous;
        int start;
        int ip_end;
        int arp_end;
        m_tready = 1'b1;
        push_frame(1, 11, 2, 4'hF);
        push_frame(0, 4, 3, 4'b0111);
        start = cyc;
        fork
            begin send_frame(1, 11, 2, 4'hF); arp_end = cyc; end
            begin send_frame(0, 4, 3, 4'b0111); ip_end = cyc; end
        join
        checks++;
        if (arp_end - start != 12) begin
            errors++;
            $display("FAIL simul_arp_first: ARP done after %0d cycles, required 12", arp_end - start);
        end
        checks++;
        if (ip_end - start != 17) begin
            errors++;
            $display("FAIL simul_ip_after_gap: IP done after %0d cycles, required 17", ip_end - start);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL simul_drain: got %0d beats outstanding, required 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_starvation;
        m_tready = 1'b1;
        for (int k = 0; k < 4; k++) push_frame(1, 2, 10 + k, 4'hF);
        push_frame(0, 2, 10, 4'hF);
        for (int k = 4; k < 8; k++) push_frame(1, 2, 10 + k, 4'hF);
        push_frame(0, 2, 11, 4'hF);
        for (int k = 8; k < 10; k++) push_frame(1, 2, 10 + k, 4'hF);
        fork
            for (int k = 0; k < 10; k++) send_frame(1, 2, 10 + k, 4'hF);
            for (int k = 0; k < 2; k++) send_frame(0, 2, 10 + k, 4'hF);
        join
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL starve_drain: got %0d beats outstanding, required 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_stall;
        bit    pat[4];
        int    stalls;
        bit    stalled;
        beat_t held;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        stalls = 0;
        stalled = 1'b0;
        held = '0;
        push_frame(0, 6, 30, 4'b0001);
        push_frame(1, 2, 31, 4'hF);
        fork
            send_frame(0, 6, 30, 4'b0001);
            begin
                @(posedge clk);
                #1;
                send_frame(1, 2, 31, 4'hF);
            end
            begin
                for (int i = 0; i < 30; i++) begin
                    m_tready = pat[i % 4];
                    @(posedge clk);
                    #1;
                end
                m_tready = 1'b1;
            end
            begin
                for (int i = 0; i < 30; i++) begin
                    @(negedge clk);
                    if (stalled) begin
                        checks++;
                        if ({m_tvalid, m_tdata, m_tkeep, m_tlast} !== {1'b1, held.data, held.keep, held.last}) begin
                            errors++;
                            $display("FAIL stall_hold: got valid=%b data=%h, required valid=1 data=%h",
                                     m_tvalid, m_tdata, held.data);
                        end
                    end
                    if (grant_ip) begin
                        checks++;
                        if (arp_tready !== 1'b0) begin
                            errors++;
                            $display("FAIL stall_arp_blocked: got arp_tready=%b, required 0", arp_tready);
                        end
                    end
                    stalled = m_tvalid && !m_tready;
                    if (stalled) stalls++;
                    held = '{data: m_tdata, keep: m_tkeep, last: m_tlast};
                end
            end
        join
        checks++;
        if (stalls == 0) begin
            errors++;
            $display("FAIL stall_seen: got %0d stalled cycles, required at least 1", stalls);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL stall_drain: got %0d beats outstanding, required 0", exp_q.size());
        end
        m_tready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_frame;
        int start;
        m_tready = 1'b1;
        exp_q.push_back(mk_beat(1, 40, 0, 8, 4'hF));
        exp_q.push_back(mk_beat(1, 40, 1, 8, 4'hF));
        for (int b = 0; b < 2; b++) begin
            int guard;
            drive_src(1, mk_beat(1, 40, b, 8, 4'hF), 1'b1);
            guard = 0;
            @(negedge clk);
            while (!arp_tready && guard <= 100) begin
                guard++;
                @(negedge clk);
            end
            if (guard > 100) begin
                checks++;
                errors++;
                $display("FAIL reset_mid_handshake: beat %0d not accepted, required within 100 cycles", b);
            end
            @(posedge clk);
            #1;
        end
        drive_src(1, mk_beat(1, 40, 2, 8, 4'hF), 1'b1);
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if ({m_tdata, m_tkeep, m_tvalid, m_tlast, ip_tready, arp_tready, grant_arp, grant_ip, busy} !== '0) begin
            errors++;
            $display("FAIL reset_async: got tvalid=%b arp_tready=%b grant_arp=%b busy=%b data=%h, required all 0",
                     m_tvalid, arp_tready, grant_arp, busy, m_tdata);
        end
        drive_src(1, '0, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, grant_arp, grant_ip} !== 3'b000) begin
            errors++;
            $display("FAIL reset_release_idle: got busy=%b grant=%b/%b, required 0", busy, grant_arp, grant_ip);
        end
        @(posedge clk);
        #1;
        push_frame(0, 3, 41, 4'b1111);
        start = cyc;
        send_frame(0, 3, 41, 4'b1111);
        checks++;
        if (cyc - start != 4) begin
            errors++;
            $display("FAIL reset_then_ip: got %0d cycles, required 4", cyc - start);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL reset_drain: got %0d beats outstanding, required 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_stats;
        logic [15:0] exp_ip;
        logic [15:0] exp_arp;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_tready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            push_frame(0, 2, 50 + k, 4'hF);
            send_frame(0, 2, 50 + k, 4'hF);
        end
        for (int k = 0; k < 2; k++) begin
            push_frame(1, 3, 60 + k, 4'b0011);
            send_frame(1, 3, 60 + k, 4'b0011);
        end
        @(negedge clk);
`ifdef TX_ARB_STATS_EN
        exp_ip  = 16'd3;
        exp_arp = 16'd2;
`else
        exp_ip  = 16'd0;
        exp_arp = 16'd0;
`endif
        checks++;
        if (ip_frames !== exp_ip) begin
            errors++;
            $display("FAIL stats_ip_frames: got %0d, required %0d", ip_frames, exp_ip);
        end
        checks++;
        if (arp_frames !== exp_arp) begin
            errors++;
            $display("FAIL stats_arp_frames: got %0d, required %0d", arp_frames, exp_arp);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL stats_drain: got %0d beats outstanding, required 0", exp_q.size());
        end
    endtask

    initial begin
        reset = 1'b1;
        m_tready = 1'b0;
        ip_tdata = '0; ip_tkeep = '0; ip_tvalid = 1'b0; ip_tlast = 1'b0;
        arp_tdata = '0; arp_tkeep = '0; arp_tvalid = 1'b0; arp_tlast = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_single_ip();
        test_simultaneous();
        test_starvation();
        test_stall();
        test_reset_mid_frame();
        test_stats();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tx_frame_arbiter.md
Name: tx_frame_arbiter

Overview:
- Frame-granular arbiter between the IP transmit stream (from ip_send) and the ARP transmit stream (from arp_send).
- Merges both onto one 32-bit AXI-stream feeding the 32-to-8 width converter.
- Grant is held for a whole frame: once a frame starts, it runs until tlast.
- ARP has priority, but a starvation limit guarantees IP progress under ARP flooding.

Parameters:
- DATA_W, 32, stream data width in bits.
- KEEP_W, 4, byte-enable width (DATA_W/8).
- STARVE_LIMIT, 4, consecutive ARP grants allowed while IP is waiting, before IP is forced; range 1..15.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous reset, active-high.
- ip_tdata  in  DATA_W  IP frame data.
- ip_tkeep  in  KEEP_W  IP byte enables.
- ip_tvalid  in  1  IP beat valid.
- ip_tlast  in  1  IP last beat of frame.
- ip_tready  out  1  IP beat accepted.
- arp_tdata  in  DATA_W  ARP frame data.
- arp_tkeep  in  KEEP_W  ARP byte enables.
- arp_tvalid  in  1  ARP beat valid.
- arp_tlast  in  1  ARP last beat of frame.
- arp_tready  out  1  ARP beat accepted.
- m_tdata  out  DATA_W  merged data.
- m_tkeep  out  KEEP_W  merged byte enables.
- m_tvalid  out  1  merged beat valid.
- m_tlast  out  1  merged last beat.
- m_tready  in  1  downstream ready.
- grant_arp  out  1  ARP currently owns the output.
- grant_ip  out  1  IP currently owns the output.
- busy  out  1  a frame is in progress.
- ip_frames  out  16  IP frame count (stats build only, else 0).
- arp_frames  out  16  ARP frame count (stats build only, else 0).

Behaviour:
- Reset values: all tready, m_tvalid, m_tlast, grant_*, busy = 0; m_tdata and m_tkeep = 0; starve_cnt = 0; state = IDLE.
- States: IDLE, GRANT_ARP, GRANT_IP.
- Decision in IDLE, made once per cycle from the tvalid inputs:
  - arp_tvalid and not (ip_tvalid and starve_cnt == STARVE_LIMIT) -> GRANT_ARP.
  - else ip_tvalid -> GRANT_IP.
  - else stay in IDLE.
- Latency: the grant register is set on the decision cycle. The first beat is presented the following cycle, so there is 1 cycle of arbitration overhead per frame.
- Datapath in GRANT_x:
  - Zero-latency mux: m_t* = x_t*, x_tready = m_tready, other-side tready = 0.
  - busy = 1; grant_x = 1.
- Beat transfer means x_tvalid and m_tready in the same cycle.
- On a transfer with x_tlast: return to IDLE next cycle; grants drop and busy drops.
- Back-to-back frames: no transfer is accepted in IDLE, so there is always at least one idle cycle between frames.
- starve_cnt (4 bits):
  - On entering GRANT_ARP while ip_tvalid = 1: increment, saturating at STARVE_LIMIT.
  - On entering GRANT_IP: clear to 0.
  - On entering GRANT_ARP with ip_tvalid = 0: unchanged.
- Source drops tvalid mid-frame: the grant is held. m_tvalid follows, and the other source stays blocked until tlast.
- m_tready low: the output holds, the upstream source stalls, and no beat is lost or duplicated.
- Simultaneous first request: ARP wins unless the starvation limit has been reached.
- Reset mid-frame: returns to IDLE immediately and all counts clear. The partial frame is truncated without tlast; upstream blocks must also be reset.
- AXI rule: m_tdata, m_tkeep and m_tlast are stable while m_tvalid = 1 and m_tready = 0, because they pass through from a stable source.

Optional Feature:
- Macro TX_ARB_STATS_EN.
- When defined: ip_frames and arp_frames increment on each accepted tlast beat of their source. They wrap modulo 2^16 and clear on reset.
- When undefined: the counters are not built and both ports are tied to 0.

Decomposition:
- Shared package tx_pkg holds:
  - DATA_W and KEEP_W.
  - The arbiter state enum typedef (IDLE / GRANT_ARP / GRANT_IP).
  - The source-ID constants SRC_IP and SRC_ARP, reused by send_buffer.
- One natural sub-module, tx_arb_mux: the combinational payload and tready mux, selected by the grant.

Test Plan:
- Single IP frame of 5 beats, last tkeep 4'b0011, m_tready = 1:
  - Decision cycle, then 5 contiguous beats.
  - m_tlast on beat 5 with tkeep 0011.
  - busy low the cycle after.
- ARP (11 beats) and IP (4 beats) both valid in the same cycle:
  - The ARP frame is output first, complete.
  - One IP-free cycle follows (the IDLE decision cycle), then the IP frame.
- ARP continuously valid, IP valid, STARVE_LIMIT = 4:
  - Grant order is ARP, ARP, ARP, ARP, IP, ARP...
  - starve_cnt clears at the IP grant.
- m_tready toggles 1,0,0,1 during a 6-beat IP frame while arp_tvalid is asserted:
  - Beats are unchanged while stalled.
  - arp_tready = 0 throughout.
  - ARP is granted only after IP tlast.
- Reset asserted on beat 3 of 8 of an ARP frame:
  - All outputs are 0 in the same cycle (asynchronous).
  - After release, the state is IDLE and a new IP frame is granted normally.
- With TX_ARB_STATS_EN, send 3 IP and 2 ARP frames -> ip_frames = 3, arp_frames = 2. Without the macro, both read 0.
